// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV host loader and engine: widths, SRAM A
// address map, start-flag value and the loader state encoding.
package spmv_pkg;

   localparam int ADDR_W = 5;
   localparam int LINE_W = 256;
   localparam int WORD_W = 32;
   localparam int LANES  = LINE_W / WORD_W;
   localparam int LANE_W = $clog2(LANES);
   localparam int SETTLE = 2;

   localparam logic [ADDR_W-1:0] FLAG_ADDR       = 5'd0;
   localparam logic [ADDR_W-1:0] FIRST_LINE_ADDR = 5'd1;
   localparam logic [ADDR_W-1:0] LAST_LINE_ADDR  = 5'd31;
   localparam logic [WORD_W-1:0] START_FLAG      = 32'h1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_WRITE = 3'd2,
      ST_FLAG  = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DONE  = 3'd5,
      ST_DRAIN = 3'd6
   } state_t;

endpackage

// File: rtl/spmv_line_packer.sv
// Packs 32-bit words into one 256-bit line, lane 0 in the low bits, and
// remembers whether the packet's last word has been loaded.
module spmv_line_packer
   import spmv_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic [WORD_W-1:0] data,
   input  logic              last,
   output logic [LINE_W-1:0] line,
   output logic              at_end,
   output logic              last_seen
);

   logic [LANES-1:0][WORD_W-1:0] lanes;
   logic [LANE_W-1:0]            lane;
   logic [LANE_W-1:0]            lane_idx;

   // A clear in the same cycle as a load restarts the line at lane 0.
   assign lane_idx = clear ? '0 : lane;
   assign at_end   = (lane_idx == LANE_W'(LANES - 1));
   assign line     = lanes;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lanes     <= '0;
         lane      <= '0;
         last_seen <= 1'b0;
      end else begin
         if (clear) begin
            lanes     <= '0;
            lane      <= '0;
            last_seen <= 1'b0;
         end
         if (load) begin
            lanes[lane_idx] <= data;
            lane            <= lane_idx + LANE_W'(1);
            if (last) begin
               last_seen <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spmv_host_loader.sv
// Host-side feeder for SRAM A port 2: packs a word stream into lines 1..31,
// writes the start flag at address 0, then polls until the engine clears it.
module spmv_host_loader
   import spmv_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_in_valid,
   input  logic [WORD_W-1:0] i_in_data,
   input  logic              i_in_last,
   output logic              o_in_ready,
   output logic [ADDR_W-1:0] o_address,
   output logic              o_wr_en,
   output logic [LINE_W-1:0] o_write_data,
   input  logic [LINE_W-1:0] i_read_data,
   output logic [2:0]        o_state,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error
);

   localparam logic [1:0] SETTLE_LAST = 2'(SETTLE);

   state_t            state;
   logic [ADDR_W-1:0] line_addr;
   logic [1:0]        settle_cnt;
   logic              accept;
   logic              pk_clear;
   logic              pk_load;
   logic              pk_at_end;
   logic              pk_last;
   logic [LINE_W-1:0] pk_line;
   logic              unused_read_bits;

   // Handshake: a word transfers on a rising edge where i_in_valid and
   // o_in_ready are both high; ready depends on state only, never on valid.
   assign o_in_ready = (state == ST_IDLE) || (state == ST_FILL) || (state == ST_DRAIN);
   assign accept     = i_in_valid && o_in_ready;
   assign pk_load    = accept && (state != ST_DRAIN);
   assign pk_clear   = (state == ST_IDLE) || (state == ST_WRITE);

   assign o_state = state;
   assign o_busy  = (state != ST_IDLE);
   assign o_done  = (state == ST_DONE);
   assign o_error = (state == ST_DRAIN) && accept && i_in_last;

   assign unused_read_bits = ^i_read_data[LINE_W-1:WORD_W];

   spmv_line_packer u_packer (
      .clk       (i_clk),
      .rst_n     (i_rstn),
      .clear     (pk_clear),
      .load      (pk_load),
      .data      (i_in_data),
      .last      (i_in_last),
      .line      (pk_line),
      .at_end    (pk_at_end),
      .last_seen (pk_last)
   );

   always_comb begin
      o_address    = '0;
      o_wr_en      = 1'b0;
      o_write_data = '0;
      case (state)
         ST_WRITE: begin
            o_address    = line_addr;
            o_wr_en      = 1'b1;
            o_write_data = pk_line;
         end
         ST_FLAG: begin
            o_address    = FLAG_ADDR;
            o_wr_en      = 1'b1;
            o_write_data = {{(LINE_W-WORD_W){1'b0}}, START_FLAG};
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state      <= ST_IDLE;
         line_addr  <= '0;
         settle_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               line_addr  <= FIRST_LINE_ADDR;
               settle_cnt <= '0;
               if (accept) begin
                  state <= i_in_last ? ST_WRITE : ST_FILL;
               end
            end
            ST_FILL: begin
               if (accept && (pk_at_end || i_in_last)) begin
                  state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (pk_last) begin
                  state <= ST_FLAG;
               end else if (line_addr == LAST_LINE_ADDR) begin
                  state <= ST_DRAIN;
               end else begin
                  line_addr <= line_addr + ADDR_W'(1);
                  state     <= ST_FILL;
               end
            end
            ST_FLAG: begin
               settle_cnt <= '0;
               state      <= ST_WAIT;
            end
            // Early read data can predate the flag write, so it is skipped.
            ST_WAIT: begin
               if (settle_cnt < SETTLE_LAST) begin
                  settle_cnt <= settle_cnt + 2'd1;
               end else if (i_read_data[WORD_W-1:0] == '0) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            ST_DRAIN: begin
               if (accept && i_in_last) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spmv_host_loader.sv
// Directed bench for spmv_host_loader with an SRAM A model and a write
// scoreboard of expected {address, line} pairs.
module tb_spmv_host_loader;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [31:0]  in_data = '0;
   logic         in_last = 1'b0;
   logic         in_ready;
   logic [4:0]   address;
   logic         wr_en;
   logic [255:0] write_data;
   logic [255:0] read_data;
   logic [2:0]   state;
   logic         busy;
   logic         done;
   logic         error;

   logic [255:0] mem [0:31];
   logic         clear_req = 1'b0;
   logic [260:0] exp_q [$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int flag_cyc = 0;
   int last_cyc = 0;
   logic prev_pulse = 1'b0;

   spmv_host_loader dut (
      .i_clk        (clk),
      .i_rstn       (rst_n),
      .i_in_valid   (in_valid),
      .i_in_data    (in_data),
      .i_in_last    (in_last),
      .o_in_ready   (in_ready),
      .o_address    (address),
      .o_wr_en      (wr_en),
      .o_write_data (write_data),
      .i_read_data  (read_data),
      .o_state      (state),
      .o_busy       (busy),
      .o_done       (done),
      .o_error      (error)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM A port 2 with one-cycle read latency; the engine side only clears word 0
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
         read_data <= '0;
      end else begin
         if (wr_en) mem[address] <= write_data;
         if (clear_req) mem[0] <= '0;
         read_data <= mem[address];
      end
   end

   task automatic check(input string tag, input logic [260:0] obs, input logic [260:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // scoreboard and per-cycle bus checks
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_pulse = 1'b0;
      end else begin
         logic [260:0] exp;
         check("busy_decode", busy, state != 3'd0);
         check("ready_decode", in_ready, !(state inside {3'd2, 3'd3, 3'd4, 3'd5}));
         check("pulse_excl", done & error, 1'b0);
         check("pulse_gap", (done | error) & prev_pulse, 1'b0);
         prev_pulse = done | error;
         if (done) done_cnt++;
         if (error) err_cnt++;
         if (wr_en) begin
            check("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               exp = exp_q.pop_front();
               check("write", {address, write_data}, exp);
            end
            if (address == 5'd0) flag_cyc = cyc + 1;
         end else begin
            check("idle_bus", {address, write_data}, 261'd0);
         end
      end
   end

   // driver tasks
   task automatic send_word(input logic [31:0] d, input logic l, input bit gaps);
      int budget;
      if (gaps) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      budget   = 0;
      while (!in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 200) check("accept_timeout", in_ready, 1'b1);
      @(negedge clk);
      if (l) last_cyc = cyc;
   endtask

   task automatic send_packet(input logic [31:0] first, input int n, input bit gaps);
      for (int i = 0; i < n; i++) send_word(first + 32'(i), (i == n - 1), gaps);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_sb_empty(input int limit);
      int b = 0;
      while (exp_q.size() != 0 && b < limit) begin
         @(negedge clk);
         b++;
      end
      check("sb_drained", exp_q.size(), 0);
   endtask

   task automatic finish_packet();
      int d0 = done_cnt;
      int b = 0;
      repeat (20) @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      while (done_cnt == d0 && b < 30) begin
         @(negedge clk);
         b++;
      end
      @(negedge clk);
      check("done_pulses", done_cnt - d0, 1);
      check("back_to_idle", state, 3'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_state", state, 3'd0);
      check("rst_bus", {address, write_data}, 261'd0);
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_flags", {done, error, busy}, 3'b000);
      check("rst_ready", in_ready, 1'b1);
   endtask

   initial begin
      logic [255:0] line;
      int d0;
      int e0;
      int stuck;

      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      @(negedge clk);

      // words 1..8 in one line, then the start flag
      exp_q.push_back({5'd1, 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001});
      exp_q.push_back({5'd0, 256'h1});
      send_packet(32'h1, 8, 1'b0);
      wait_sb_empty(50);
      check("flag_latency", flag_cyc - last_cyc, 2);
      finish_packet();

      // 11 words: one full line plus a partial line with zeroed upper lanes
      exp_q.push_back({5'd1, 256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0});
      exp_q.push_back({5'd2, 256'h00000000_00000000_00000000_00000000_00000000_000000AA_000000A9_000000A8});
      exp_q.push_back({5'd0, 256'h1});
      send_packet(32'hA0, 11, 1'b0);
      wait_sb_empty(50);
      finish_packet();

      // first packet again with random valid gaps
      exp_q.push_back({5'd1, 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001});
      exp_q.push_back({5'd0, 256'h1});
      send_packet(32'h1, 8, 1'b1);
      wait_sb_empty(100);
      finish_packet();

      // overflow: 31 full lines, the 249th word is dropped and no flag is written
      for (int n = 1; n <= 31; n++) begin
         for (int k = 0; k < 8; k++) line[32*k +: 32] = 32'(8 * (n - 1) + k + 1);
         exp_q.push_back({5'(n), line});
      end
      d0 = done_cnt;
      e0 = err_cnt;
      send_packet(32'h1, 249, 1'b0);
      @(negedge clk);
      check("overflow_error", err_cnt - e0, 1);
      check("overflow_no_done", done_cnt - d0, 0);
      check("overflow_writes", exp_q.size(), 0);
      check("overflow_idle", state, 3'd0);
      check("overflow_flag_word", mem[0][31:0], 32'h0);

      // flag never cleared: loader must hold in WAIT
      exp_q.push_back({5'd1, 256'h55});
      exp_q.push_back({5'd0, 256'h1});
      send_packet(32'h55, 1, 1'b0);
      wait_sb_empty(50);
      stuck = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (state != 3'd4 || !busy || in_ready) stuck++;
      end
      check("wait_hold", stuck, 0);

      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset after five words, then a clean packet at address 1
      for (int i = 0; i < 5; i++) send_word(32'h77 + 32'(i), 1'b0, 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_q.push_back({5'd1, 256'h00000018_00000017_00000016_00000015_00000014_00000013_00000012_00000011});
      exp_q.push_back({5'd0, 256'h1});
      send_packet(32'h11, 8, 1'b0);
      wait_sb_empty(50);
      finish_packet();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
